// File: rtl/mapped_ram.sv
// mapped_ram: byte-wide RAM window decoded from a 16-bit bus at [base, base+size).
// Define RAM_CLEAR_ON_RESET_EN to add a post-reset zeroing sweep reported on clear_busy.
module mapped_ram #(
    parameter int unsigned base     = 16'h0000,
    parameter int unsigned size     = 16'h2000,
    parameter int unsigned addrbits = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    output logic [7:0]  data_read,
    input  logic [7:0]  data_write,
    input  logic        do_write,
    output logic        data_active,
    output logic        clear_busy
);

    // 17-bit bounds so a window ending exactly at 0x10000 does not wrap to zero.
    localparam logic [16:0] BASE_X = 17'(base);
    localparam logic [16:0] END_X  = 17'(base + size);

    logic [7:0]          mem [size];
    logic [16:0]         addr_x;
    logic                in_range;
    logic [addrbits-1:0] index;
    logic                mem_we;
    logic [addrbits-1:0] mem_widx;
    logic [7:0]          mem_wdata;

    assign addr_x   = {1'b0, addr};
    assign in_range = (addr_x >= BASE_X) && (addr_x < END_X);
    assign index    = addrbits'(addr - 16'(base));

`ifdef RAM_CLEAR_ON_RESET_EN
    logic [addrbits-1:0] clr_ptr_d;
    logic [addrbits-1:0] clr_ptr_q;
    logic                clear_busy_d;
    logic                clear_busy_q;

    // Reset (re)arms the sweep; each reset-free busy cycle zeroes one location.
    always_comb begin
        clr_ptr_d    = clr_ptr_q;
        clear_busy_d = clear_busy_q;
        if (reset) begin
            clr_ptr_d    = '0;
            clear_busy_d = 1'b1;
        end else if (clear_busy_q) begin
            clr_ptr_d = clr_ptr_q + addrbits'(1);
            if (clr_ptr_q == addrbits'(size - 1)) begin
                clear_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        clr_ptr_q    <= clr_ptr_d;
        clear_busy_q <= clear_busy_d;
    end

    assign clear_busy = clear_busy_q;
`else
    assign clear_busy = 1'b0;
`endif

    always_comb begin
        mem_we    = do_write && in_range && !reset && !clear_busy;
        mem_widx  = index;
        mem_wdata = data_write;
`ifdef RAM_CLEAR_ON_RESET_EN
        // The sweep owns the single write port while it runs.
        if (clear_busy_q) begin
            mem_we    = !reset;
            mem_widx  = clr_ptr_q;
            mem_wdata = 8'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Idle value 0xFF lets the bus mux treat an inactive slave as open bus.
    assign data_active = in_range && !do_write && !clear_busy;
    assign data_read   = data_active ? mem[index] : 8'hFF;

endmodule

// File: tb/tb_mapped_ram.sv
// Self-checking bench for mapped_ram; expected read results queue up as stimulus is driven.
module tb_mapped_ram;

`ifdef RAM_CLEAR_ON_RESET_EN
    localparam int SIZE = 16;
    localparam int AB   = 4;
`else
    localparam int SIZE = 'h2000;
    localparam int AB   = 13;
`endif
    localparam int BASE = 'h8000;

    localparam logic [15:0] A_BASE = 16'(BASE);
    localparam logic [15:0] A_BELOW = 16'(BASE - 1);
    localparam logic [15:0] A_LAST = 16'(BASE + SIZE - 1);
    localparam logic [15:0] A_PAST = 16'(BASE + SIZE);
    localparam logic [15:0] A_MID = 16'(BASE + SIZE / 2);
    localparam logic [15:0] A_MID3 = 16'(BASE + SIZE / 2 + 3);

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  data_read;
    logic [7:0]  data_write;
    logic        do_write;
    logic        data_active;
    logic        clear_busy;

    typedef struct {
        string      nm;
        logic       act;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    mapped_ram #(
        .base(BASE),
        .size(SIZE),
        .addrbits(AB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .data_read(data_read),
        .data_write(data_write),
        .do_write(do_write),
        .data_active(data_active),
        .clear_busy(clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic drive_rd(input logic [15:0] a, input logic [7:0] d, input logic act,
                            input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        addr     = a;
        do_write = 1'b0;
        e.nm = nm;
        e.act = act;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        addr       = a;
        data_write = d;
        do_write   = 1'b1;
        @(posedge clk);
        #1;
        do_write = 1'b0;
    endtask

`ifdef RAM_CLEAR_ON_RESET_EN
    task automatic wait_clear(input string nm);
        bit done = 0;
        for (int i = 0; i < SIZE + 8; i++) begin
            @(negedge clk);
            if (!clear_busy) begin
                done = 1;
                break;
            end
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s: clear_busy still 1 after %0d cycles, required 0", nm, SIZE + 8);
        end
    endtask
`endif

    task automatic test_reset();
        exp_t e;
        logic exp_busy;
`ifdef RAM_CLEAR_ON_RESET_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        reset = 1'b1;
        do_write = 1'b0;
        addr = A_BELOW;
        data_write = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (clear_busy !== exp_busy) begin
            miscompares++;
            $display("FAIL reset_busy: clear_busy=%b required %b", clear_busy, exp_busy);
        end
        drive_rd(A_BELOW, 8'hFF, 1'b0, "reset_below");
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (data_active !== e.act || data_read !== e.data) begin
            miscompares++;
            $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                     e.nm, data_active, data_read, e.act, e.data);
        end
`ifdef RAM_CLEAR_ON_RESET_EN
        drive_rd(A_BASE, 8'hFF, 1'b0, "reset_busy_read");
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (data_active !== e.act || data_read !== e.data) begin
            miscompares++;
            $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                     e.nm, data_active, data_read, e.act, e.data);
        end
        wait_clear("reset_sweep_done");
`endif
    endtask

    task automatic test_basic_rw();
        logic [15:0] a[2];
        logic [7:0]  d[2];
        exp_t e;
        a[0] = A_BASE; d[0] = 8'hA5;
        a[1] = A_LAST; d[1] = 8'h3C;
        for (int i = 0; i < 2; i++) wr(a[i], d[i]);
        for (int i = 0; i < 2; i++) begin
            drive_rd(a[i], d[i], 1'b1, $sformatf("basic_rd_%h", a[i]));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (data_active !== e.act || data_read !== e.data) begin
                miscompares++;
                $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                         e.nm, data_active, data_read, e.act, e.data);
            end
        end
    endtask

    task automatic test_range();
        logic [15:0] a[4];
        logic [7:0]  d[4];
        logic        act[4];
        exp_t e;
        a[0] = A_BELOW; d[0] = 8'hFF; act[0] = 1'b0;
        a[1] = A_PAST;  d[1] = 8'hFF; act[1] = 1'b0;
        a[2] = A_BASE;  d[2] = 8'hA5; act[2] = 1'b1;
        a[3] = A_LAST;  d[3] = 8'h3C; act[3] = 1'b1;
        wr(A_PAST, 8'h11);
        for (int i = 0; i < 4; i++) begin
            drive_rd(a[i], d[i], act[i], $sformatf("range_rd_%h", a[i]));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (data_active !== e.act || data_read !== e.data) begin
                miscompares++;
                $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                         e.nm, data_active, data_read, e.act, e.data);
            end
        end
    endtask

    task automatic test_read_during_write();
        exp_t e;
        @(posedge clk);
        #1;
        addr = A_MID;
        data_write = 8'h77;
        do_write = 1'b1;
        e.nm = "rdw_same_cycle";
        e.act = 1'b0;
        e.data = 8'hFF;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (data_active !== e.act || data_read !== e.data) begin
            miscompares++;
            $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                     e.nm, data_active, data_read, e.act, e.data);
        end
        drive_rd(A_MID, 8'h77, 1'b1, "rdw_next_cycle");
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (data_active !== e.act || data_read !== e.data) begin
            miscompares++;
            $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                     e.nm, data_active, data_read, e.act, e.data);
        end
    endtask

    task automatic test_reset_write();
        exp_t e;
        logic [7:0] exp_d;
        wr(A_MID3, 8'h42);
        @(posedge clk);
        #1;
        reset = 1'b1;
        addr = A_MID3;
        data_write = 8'h5A;
        do_write = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        do_write = 1'b0;
`ifdef RAM_CLEAR_ON_RESET_EN
        exp_d = 8'h00;
        wait_clear("rstwr_sweep_done");
`else
        exp_d = 8'h42;
`endif
        drive_rd(A_MID3, exp_d, 1'b1, "reset_write_dropped");
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (data_active !== e.act || data_read !== e.data) begin
            miscompares++;
            $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                     e.nm, data_active, data_read, e.act, e.data);
        end
    endtask

`ifdef RAM_CLEAR_ON_RESET_EN
    task automatic test_clear_sweep();
        exp_t e;
        int cnt = 0;
        bit bad_busy_read = 0;
        for (int i = 0; i < SIZE; i++) wr(16'(BASE + i), 8'hEE);
        drive_rd(16'(BASE + 5), 8'hEE, 1'b1, "clear_prefill");
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (data_active !== e.act || data_read !== e.data) begin
            miscompares++;
            $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                     e.nm, data_active, data_read, e.act, e.data);
        end
        @(posedge clk);
        #1;
        addr = 16'(BASE + 2);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4 * SIZE; i++) begin
            @(negedge clk);
            if (!clear_busy) break;
            cnt++;
            if (data_read !== 8'hFF || data_active !== 1'b0) bad_busy_read = 1;
        end
        vectors++;
        if (cnt != SIZE) begin
            miscompares++;
            $display("FAIL clear_busy_len: %0d cycles required %0d", cnt, SIZE);
        end
        vectors++;
        if (bad_busy_read) begin
            miscompares++;
            $display("FAIL clear_busy_read: saw active read while busy, required act=0 data=ff");
        end
        for (int i = 0; i < SIZE; i++) begin
            drive_rd(16'(BASE + i), 8'h00, 1'b1, $sformatf("cleared_%0d", i));
            @(negedge clk);
            e = exp_q.pop_front();
            vectors++;
            if (data_active !== e.act || data_read !== e.data) begin
                miscompares++;
                $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                         e.nm, data_active, data_read, e.act, e.data);
            end
        end
    endtask

    task automatic test_clear_restart();
        exp_t e;
        int cnt = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        addr = A_BASE;
        data_write = 8'h99;
        do_write = 1'b1;
        for (int i = 0; i < 4 * SIZE; i++) begin
            @(negedge clk);
            if (!clear_busy) break;
            cnt++;
        end
        do_write = 1'b0;
        vectors++;
        if (cnt != SIZE) begin
            miscompares++;
            $display("FAIL restart_busy_len: %0d cycles required %0d", cnt, SIZE);
        end
        drive_rd(A_BASE, 8'h00, 1'b1, "busy_write_ignored");
        @(negedge clk);
        e = exp_q.pop_front();
        vectors++;
        if (data_active !== e.act || data_read !== e.data) begin
            miscompares++;
            $display("FAIL %s: act=%b data=%h required act=%b data=%h",
                     e.nm, data_active, data_read, e.act, e.data);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_rw();
        test_range();
        test_read_during_write();
        test_reset_write();
`ifdef RAM_CLEAR_ON_RESET_EN
        test_clear_sweep();
        test_clear_restart();
`endif
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
